// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and parameters for the register-file writeback arbiter
package regfile_wb_arbiter_pkg;

  localparam int NUM_REGS         = 32;
  localparam int WB_N_REQ_DEFAULT = 3;

  typedef logic [$clog2(NUM_REGS)-1:0] reg_id_t;
  typedef logic [31:0]                 op_t;

  typedef struct packed {
    reg_id_t id;
    op_t     data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, register-file write and scoreboard signals
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = WB_N_REQ_DEFAULT
) ();

  logic    [N_REQ-1:0]    req_valid;
  reg_id_t [N_REQ-1:0]    req_id;
  op_t     [N_REQ-1:0]    req_data;
  logic    [N_REQ-1:0]    req_ready;
  logic                   wb_enable;
  reg_id_t                wb_id;
  op_t                    wb_data;
  logic                   claim_valid;
  reg_id_t                claim_id;
  logic    [NUM_REGS-1:0] busy_mask;

  modport master (
    output req_valid, req_id, req_data, claim_valid, claim_id,
    input  req_ready, wb_enable, wb_id, wb_data, busy_mask
  );

  modport slave (
    input  req_valid, req_id, req_data, claim_valid, claim_id,
    output req_ready, wb_enable, wb_id, wb_data, busy_mask
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_grant.sv
// rtl/regfile_wb_arbiter_rr_grant.sv - combinational round-robin picker: first request at or after rr_ptr
module regfile_wb_arbiter_rr_grant #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          found
);

  always_comb begin
    int           j;
    logic [N-1:0] req_shift;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      req_shift = req >> j;
      if (!found && req_shift[0]) begin
        found = 1'b1;
        idx   = PW'(j);
        grant = N'(1) << j;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register file write port
// Optional pending-write scoreboard built when WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = WB_N_REQ_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    sel_idx;
  logic [N_REQ-1:0] grant;
  logic             found;
  wb_req_t          sel;
  logic             wb_enable_q;
  reg_id_t          wb_id_q;
  op_t              wb_data_q;

  regfile_wb_arbiter_rr_grant #(.N(N_REQ), .PW(PW)) u_rr_grant (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .idx    (sel_idx),
    .found  (found)
  );

  // Grant is held off during reset so no requester sees a handshake it cannot complete.
  assign bus.req_ready = rst_n ? grant : '0;

  always_comb begin
    sel      = '0;
    sel.id   = bus.req_id[sel_idx];
    sel.data = bus.req_data[sel_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      wb_enable_q <= 1'b0;
      wb_id_q     <= '0;
      wb_data_q   <= '0;
    end else if (found) begin
      rr_ptr      <= (sel_idx == PW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
      wb_enable_q <= (sel.id != '0);
      wb_id_q     <= sel.id;
      wb_data_q   <= sel.data;
    end else begin
      wb_enable_q <= 1'b0;
    end
  end

  assign bus.wb_enable = wb_enable_q;
  assign bus.wb_id     = wb_id_q;
  assign bus.wb_data   = wb_data_q;

`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Clear first, then claim, so a same-cycle claim on the retiring id keeps it busy.
  always_comb begin
    busy_next = busy;
    if (found) busy_next[sel.id] = 1'b0;
    if (bus.claim_valid) busy_next[bus.claim_id] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign bus.busy_mask = busy;
`else
  logic unused_claim;
  assign unused_claim  = ^{bus.claim_valid, bus.claim_id};
  assign bus.busy_mask = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter against a reference model
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int N = 3;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N_REQ(N)) bus ();
  regfile_wb_arbiter #(.N_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  op_t rf [32];
  always @(negedge clk) if (bus.wb_enable === 1'b1) rf[bus.wb_id] = bus.wb_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] v;
  reg_id_t      ids  [N];
  op_t          dats [N];
  logic         cv;
  reg_id_t      cid;

  int        m_ptr;
  bit [31:0] m_busy;
  logic      m_en;
  reg_id_t   m_id;
  op_t       m_data;
  int        last_g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive();
    bus.req_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_id[i]   = ids[i];
      bus.req_data[i] = dats[i];
    end
    bus.claim_valid = cv;
    bus.claim_id    = cid;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_busy = '0; m_en = 1'b0; m_id = '0; m_data = '0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] exp_busy();
    return SB ? m_busy : 32'h0;
  endfunction

  // One handshake cycle: check the grant, step the model at posedge, check registered outputs at negedge.
  task automatic run_cycle(input string tag);
    int           g;
    logic [N-1:0] er;
    drive();
    #1;
    g      = model_grant();
    last_g = g;
    er     = (g < 0) ? '0 : (N'(1) << g);
    check({tag, "/ready"}, bus.req_ready, er);
    @(posedge clk);
    if (g >= 0) begin
      m_en   = (ids[g] != 0);
      m_id   = ids[g];
      m_data = dats[g];
      m_busy[ids[g]] = 1'b0;
      m_ptr  = (g + 1) % N;
    end else begin
      m_en = 1'b0;
    end
    if (cv && cid != 0) m_busy[cid] = 1'b1;
    @(negedge clk);
    check({tag, "/wb_enable"}, bus.wb_enable, m_en);
    check({tag, "/wb_id"},     bus.wb_id,     m_id);
    check({tag, "/wb_data"},   bus.wb_data,   m_data);
    check({tag, "/busy"},      bus.busy_mask, exp_busy());
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    rst_n = 1'b0;
    v = '1; cv = 1'b0; cid = '0;
    ids[0] = 5'd5;  ids[1] = 5'd6;  ids[2] = 5'd7;
    dats[0] = 32'hA; dats[1] = 32'hB; dats[2] = 32'hC;
    drive();
    model_reset();

    // Reset held with every requester valid.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst/ready",     bus.req_ready, 0);
      check("rst/wb_enable", bus.wb_enable, 0);
    end
    check("rst/wb_id",   bus.wb_id, 0);
    check("rst/wb_data", bus.wb_data, 0);
    check("rst/busy",    bus.busy_mask, 0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) run_cycle("rr");

    // Write to $zero from requester 1 alone.
    v = 3'b010; ids[1] = 5'd0; dats[1] = 32'hDEADBEEF;
    run_cycle("zero");
    #1;
    check("zero/rf0", rf[0], 0);
    v = '1; ids[1] = 5'd6; dats[1] = 32'hB;
    drive();
    #1;
    check("zero/next_grant", bus.req_ready, 3'b100);
    run_cycle("zero_next");

    // Scoreboard set and clear on id 9.
    v = '0; cv = 1'b1; cid = 5'd9;
    run_cycle("sb_claim");
    check("sb/set9", bus.busy_mask[9], SB);
    v = 3'b100; ids[2] = 5'd9; dats[2] = 32'h99; cv = 1'b0;
    run_cycle("sb_clear");
    check("sb/clr9", bus.busy_mask[9], 0);

    // Claim and clear of id 12 on the same edge.
    v = 3'b001; ids[0] = 5'd12; dats[0] = 32'h1212; cv = 1'b1; cid = 5'd12;
    run_cycle("sb_both");
    check("sb/both12", bus.busy_mask[12], SB);

    // Randomized traffic; a requester only changes its request once granted or idle.
    for (int c = 0; c < 60; c++) begin
      run_cycle("rand");
      for (int i = 0; i < N; i++) begin
        if (i == last_g || !v[i]) begin
          v[i]    = 1'($urandom_range(0, 1));
          ids[i]  = reg_id_t'($urandom_range(0, 31));
          dats[i] = $urandom;
        end
      end
      cv  = ($urandom_range(0, 2) == 0);
      cid = reg_id_t'($urandom_range(0, 31));
    end

    // Reset between the transfer edge and the register-file commit edge.
    v = '1; cv = 1'b1; cid = 5'd20;
    for (int i = 0; i < N; i++) begin
      ids[i]  = 5'd3;
      dats[i] = 32'h12345678;
    end
    rf[3] = '0;
    drive();
    @(posedge clk);
    #2;
    check("midrst/pre_enable", bus.wb_enable, 1);
    rst_n = 1'b0;
    #1;
    check("midrst/wb_enable", bus.wb_enable, 0);
    check("midrst/busy",      bus.busy_mask, 0);
    check("midrst/ready",     bus.req_ready, 0);
    check("midrst/wb_id",     bus.wb_id, 0);
    @(negedge clk);
    #1;
    check("midrst/rf3", rf[3], 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cv = 1'b0;
    run_cycle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
